// File: rtl/ip_commutator.sv
// Panel commutator: walks the configured panel chain, shifts each panel out on a
// divided serial clock, then latches the external chain and reports frame status.
module ip_commutator #(
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned PANELS     = 1 << SEL_WIDTH,
  parameter int unsigned PANEL_BITS = 144,
  parameter int unsigned BIT_WIDTH  = 8,
  parameter int unsigned DIV        = 250,
  parameter int unsigned DIV_WIDTH  = 8,
  parameter int unsigned FC_WIDTH   = 16
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [SEL_WIDTH:0]   ip_count,
  output logic [SEL_WIDTH-1:0] ip_step,
  input  logic [SEL_WIDTH-1:0] ip_sel,
  output logic [0:PANELS-1]    ip_clk,
  output logic [0:PANELS-1]    ip_latch,
  input  logic [0:PANELS-1]    ip_data,
  output logic                 ser_clk,
  output logic                 ser_data,
  output logic                 ser_latch,
  output logic                 ser_enable,
  output logic                 busy,
  output logic                 frame_done,
  output logic [FC_WIDTH-1:0]  frame_count
);

  localparam logic [DIV_WIDTH-1:0] DivLast  = DIV_WIDTH'(DIV - 1);
  localparam logic [DIV_WIDTH-1:0] DivPen   = DIV_WIDTH'(DIV - 2);
  localparam logic [BIT_WIDTH-1:0] BitLast  = BIT_WIDTH'(PANEL_BITS - 1);
  localparam logic [SEL_WIDTH:0]   CountMax = (SEL_WIDTH + 1)'(PANELS);

  typedef enum logic [2:0] {StIdle, StLoad, StLo, StHi, StLatch} state_e;

  state_e                state_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [BIT_WIDTH-1:0]  bit_q;
  logic [SEL_WIDTH-1:0]  step_q;
  logic                  ser_clk_q;
  logic                  ser_data_q;
  logic                  ser_latch_q;
  logic                  ser_enable_q;
  logic                  busy_q;
  logic                  frame_done_q;
  logic [FC_WIDTH-1:0]   frame_count_q;

  logic count_ok;
  logic start;
  logic div_last;
  logic sel_data;

  assign count_ok = (ip_count != '0) && (ip_count <= CountMax);
  assign start    = run && count_ok;
  assign div_last = (div_q == DivLast);

  // Strobes and data select go only to the panel addressed by ip_sel.
  always_comb begin
    sel_data = 1'b0;
    ip_clk   = '0;
    ip_latch = '0;
    for (int i = 0; i < PANELS; i++) begin
      if (ip_sel == SEL_WIDTH'(i)) begin
        sel_data    = ip_data[i];
        ip_clk[i]   = (state_q == StHi) && div_last;
        ip_latch[i] = (state_q == StLoad);
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      div_q         <= '0;
      bit_q         <= '0;
      step_q        <= '0;
      ser_clk_q     <= 1'b0;
      ser_data_q    <= 1'b0;
      ser_latch_q   <= 1'b0;
      ser_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            step_q  <= SEL_WIDTH'(ip_count - 1'b1);
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          bit_q   <= '0;
          div_q   <= '0;
          state_q <= StLo;
        end
        StLo: begin
          ser_data_q <= sel_data;
          if (div_last) begin
            div_q     <= '0;
            ser_clk_q <= 1'b1;
            state_q   <= StHi;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StHi: begin
          if (div_last) begin
            div_q     <= '0;
            ser_clk_q <= 1'b0;
            if (bit_q != BitLast) begin
              bit_q   <= bit_q + 1'b1;
              state_q <= StLo;
            end else if (step_q != '0) begin
              step_q  <= step_q - 1'b1;
              state_q <= StLoad;
            end else begin
              ser_latch_q <= 1'b1;
              state_q     <= StLatch;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StLatch: begin
          // Raised one cycle early so the registered pulse lands on the final latch cycle.
          if (div_q == DivPen) begin
            frame_done_q <= 1'b1;
          end
          if (div_last) begin
            div_q         <= '0;
            ser_latch_q   <= 1'b0;
            ser_enable_q  <= 1'b1;
            frame_count_q <= frame_count_q + 1'b1;
            if (start) begin
              step_q  <= SEL_WIDTH'(ip_count - 1'b1);
              state_q <= StLoad;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ip_step     = step_q;
  assign ser_clk     = ser_clk_q;
  assign ser_data    = ser_data_q;
  assign ser_latch   = ser_latch_q;
  assign ser_enable  = ser_enable_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ip_commutator.sv
// Randomised bench for ip_commutator: panel shift-register models plus a frame-level
// reference (expected bit stream, step order, strobe counts, frame length, frame count).
module tb_ip_commutator;

  localparam int PB = 4;
  localparam int DV = 2;
  localparam int NP = 4;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       run;
  logic [2:0] ip_count;
  logic [1:0] ip_step;
  logic [1:0] ip_sel;
  logic [0:3] ip_clk;
  logic [0:3] ip_latch;
  logic [0:3] ip_data;
  logic       ser_clk;
  logic       ser_data;
  logic       ser_latch;
  logic       ser_enable;
  logic       busy;
  logic       frame_done;
  logic [1:0] frame_count;

  ip_commutator #(
    .SEL_WIDTH (2),
    .PANELS    (NP),
    .PANEL_BITS(PB),
    .BIT_WIDTH (8),
    .DIV       (DV),
    .DIV_WIDTH (8),
    .FC_WIDTH  (2)
  ) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .run        (run),
    .ip_count   (ip_count),
    .ip_step    (ip_step),
    .ip_sel     (ip_sel),
    .ip_clk     (ip_clk),
    .ip_latch   (ip_latch),
    .ip_data    (ip_data),
    .ser_clk    (ser_clk),
    .ser_data   (ser_data),
    .ser_latch  (ser_latch),
    .ser_enable (ser_enable),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk_in = ~clk_in;

  // Config RAM and panel contents.
  logic [1:0]    cfg [NP];
  logic [PB-1:0] pat [NP];
  logic [2:0]    pos [NP];

  assign ip_sel = cfg[ip_step];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      ip_data[p] = (pos[p] < 3'd4) ? pat[p][2'(3'd3 - pos[p])] : 1'b0;
    end
  end

  // Monitor: cumulative event counters, sampled on the falling edge.
  int         busy_cyc = 0;
  int         lat_cyc = 0;
  int         done_cnt = 0;
  int         dil_cnt = 0;
  int         multi_bad = 0;
  int         bits_n = 0;
  int         step_n = 0;
  int         fc_n = 0;
  int         latch_cnt [NP] = '{default: 0};
  int         clk_cnt [NP] = '{default: 0};
  logic       bits_mem [4096];
  logic [1:0] step_log [1024];
  logic [1:0] fc_log [1024];
  logic       sclk_prev = 1'b0;
  logic       done_prev = 1'b0;

  always @(negedge clk_in) begin
    if (busy) busy_cyc <= busy_cyc + 1;
    if (ser_latch) lat_cyc <= lat_cyc + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_done && ser_latch) dil_cnt <= dil_cnt + 1;
    if ($countones(ip_clk) > 1 || $countones(ip_latch) > 1) multi_bad <= multi_bad + 1;
    sclk_prev <= ser_clk;
    if (ser_clk && !sclk_prev) begin
      bits_mem[bits_n] <= ser_data;
      bits_n           <= bits_n + 1;
    end
    done_prev <= frame_done;
    if (done_prev) begin
      fc_log[fc_n] <= frame_count;
      fc_n         <= fc_n + 1;
    end
    if (ip_latch != '0) begin
      step_log[step_n] <= ip_step;
      step_n           <= step_n + 1;
    end
    for (int p = 0; p < NP; p++) begin
      if (ip_latch[p]) begin
        latch_cnt[p] <= latch_cnt[p] + 1;
        pos[p]       <= 3'd0;
      end else if (ip_clk[p]) begin
        clk_cnt[p] <= clk_cnt[p] + 1;
        if (pos[p] < 3'd4) pos[p] <= pos[p] + 3'd1;
      end
    end
  end

  int         n_checks = 0;
  int         n_errs = 0;
  logic [1:0] fc_exp = 2'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt < target) check_eq({tag, "_timeout"}, done_cnt, target);
  endtask

  task automatic randomize_panels();
    for (int p = 0; p < NP; p++) begin
      cfg[p] = 2'($urandom);
      pat[p] = PB'($urandom);
    end
  endtask

  // One frame with run dropped and ip_count scrambled right after start.
  task automatic one_frame(input int cnt, input string tag);
    int          b_bits = bits_n;
    int          b_busy = busy_cyc;
    int          b_lat = lat_cyc;
    int          b_done = done_cnt;
    int          b_dil = dil_cnt;
    int          b_step = step_n;
    int          b_lc [NP];
    int          b_cc [NP];
    int          n = 0;
    logic [31:0] got_v = '0, exp_v = '0, got_l = '0, exp_l = '0, got_c = '0, exp_c = '0;
    for (int p = 0; p < NP; p++) begin
      b_lc[p] = latch_cnt[p];
      b_cc[p] = clk_cnt[p];
    end
    ip_count = 3'(cnt);
    run      = 1'b1;
    do begin
      tick();
      n++;
    end while (!busy && n < 10);
    check_eq({tag, "_start_latency"}, n, 1);
    ip_count = 3'($urandom);
    run      = 1'b0;
    wait_done(b_done + 1, 300, tag);
    tick();
    tick();
    fc_exp = fc_exp + 2'd1;
    for (int s = cnt - 1; s >= 0; s--) begin
      for (int b = PB - 1; b >= 0; b--) exp_v = {exp_v[30:0], pat[cfg[s]][b]};
      exp_l = exp_l + (32'd1 << (8 * cfg[s]));
      exp_c = exp_c + (32'(PB) << (8 * cfg[s]));
    end
    for (int i = 0; i < cnt * PB; i++) got_v = {got_v[30:0], bits_mem[b_bits + i]};
    for (int p = 0; p < NP; p++) begin
      got_l = got_l + (32'(latch_cnt[p] - b_lc[p]) << (8 * p));
      got_c = got_c + (32'(clk_cnt[p] - b_cc[p]) << (8 * p));
    end
    got_v = '0;
    for (int i = 0; i < cnt * PB; i++) got_v = {got_v[30:0], bits_mem[b_bits + i]};
    check_eq({tag, "_bits"}, got_v, exp_v);
    check_eq({tag, "_nbits"}, bits_n - b_bits, cnt * PB);
    exp_v = '0;
    got_v = '0;
    for (int s = cnt - 1; s >= 0; s--) exp_v = {exp_v[27:0], 4'(s)};
    for (int i = 0; i < cnt; i++) got_v = {got_v[27:0], 2'b00, step_log[b_step + i]};
    check_eq({tag, "_steps"}, got_v, exp_v);
    check_eq({tag, "_latch_pulses"}, got_l, exp_l);
    check_eq({tag, "_clk_pulses"}, got_c, exp_c);
    check_eq({tag, "_frame_len"}, busy_cyc - b_busy, cnt * (1 + 2 * DV * PB) + DV);
    check_eq({tag, "_latch_len"}, lat_cyc - b_lat, DV);
    check_eq({tag, "_done_pulses"}, done_cnt - b_done, 1);
    check_eq({tag, "_done_in_latch"}, dil_cnt - b_dil, 1);
    check_eq({tag, "_frame_count"}, frame_count, fc_exp);
    check_eq({tag, "_enable"}, ser_enable, 1);
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  task automatic illegal_count(input logic [2:0] cnt, input string tag);
    int b_busy = busy_cyc;
    int b_str = 0;
    int a_str = 0;
    for (int p = 0; p < NP; p++) b_str += latch_cnt[p] + clk_cnt[p];
    ip_count = cnt;
    run      = 1'b1;
    repeat (20) tick();
    run = 1'b0;
    for (int p = 0; p < NP; p++) a_str += latch_cnt[p] + clk_cnt[p];
    check_eq({tag, "_busy"}, busy_cyc - b_busy, 0);
    check_eq({tag, "_strobes"}, a_str - b_str, 0);
  endtask

  initial begin
    int          b_busy, b_done, b_fc, b_bits, b_lc, n, cnt;
    logic [31:0] got_v, exp_v;
    for (int p = 0; p < NP; p++) begin
      cfg[p] = 2'd0;
      pat[p] = '0;
      pos[p] = 3'd0;
    end
    reset_n  = 1'b0;
    run      = 1'b0;
    ip_count = 3'd0;
    repeat (3) tick();
    check_eq("reset_busy", busy, 0);
    check_eq("reset_enable", ser_enable, 0);
    check_eq("reset_fc", frame_count, 0);
    check_eq("reset_step", ip_step, 0);
    check_eq("reset_ser", {ser_clk, ser_data, ser_latch, frame_done}, 0);
    check_eq("reset_strobes", {ip_clk, ip_latch}, 0);
    reset_n = 1'b1;
    tick();

    illegal_count(3'd0, "illegal0");
    illegal_count(3'd5, "illegal5");
    check_eq("illegal_enable", ser_enable, 0);

    randomize_panels();
    cfg[0] = 2'd2;
    pat[2] = 4'b1011;
    one_frame(1, "single");

    randomize_panels();
    cfg[2] = 2'd3;
    cfg[1] = 2'd0;
    cfg[0] = 2'd1;
    one_frame(3, "multi");

    for (int k = 0; k < 8; k++) begin
      randomize_panels();
      one_frame($urandom_range(1, NP), "rand");
    end

    // Run held high: frames must abut with no idle cycle between them.
    randomize_panels();
    cnt      = $urandom_range(1, NP);
    b_busy   = busy_cyc;
    b_done   = done_cnt;
    b_lc     = 0;
    for (int p = 0; p < NP; p++) b_lc += latch_cnt[p];
    ip_count = 3'(cnt);
    run      = 1'b1;
    wait_done(b_done + 2, 400, "cont");
    run = 1'b0;
    wait_done(b_done + 3, 300, "cont");
    tick();
    tick();
    fc_exp = fc_exp + 2'd3;
    n = 0;
    for (int p = 0; p < NP; p++) n += latch_cnt[p];
    check_eq("cont_len", busy_cyc - b_busy, 3 * (cnt * (1 + 2 * DV * PB) + DV));
    check_eq("cont_done", done_cnt - b_done, 3);
    check_eq("cont_latches", n - b_lc, 3 * cnt);
    check_eq("cont_fc", frame_count, fc_exp);

    // Reset during the shift of the first panel (step 1).
    randomize_panels();
    ip_count = 3'd2;
    run      = 1'b1;
    n        = 0;
    do begin
      tick();
      n++;
    end while (!ser_clk && n < 50);
    check_eq("rst_reach_hi", ser_clk, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_enable", ser_enable, 0);
    check_eq("rst_fc", frame_count, 0);
    check_eq("rst_step", ip_step, 0);
    check_eq("rst_ser", {ser_clk, ser_data, ser_latch, frame_done}, 0);
    check_eq("rst_strobes", {ip_clk, ip_latch}, 0);
    run = 1'b0;
    @(posedge clk_in);
    #1;
    reset_n = 1'b1;
    fc_exp  = 2'd0;
    tick();

    // Five back-to-back single-panel frames: frame_count wraps modulo 4.
    randomize_panels();
    b_fc     = fc_n;
    b_done   = done_cnt;
    b_bits   = bits_n;
    ip_count = 3'd1;
    run      = 1'b1;
    wait_done(b_done + 4, 400, "wrap");
    run = 1'b0;
    wait_done(b_done + 5, 200, "wrap");
    tick();
    tick();
    got_v = '0;
    exp_v = '0;
    for (int k = 0; k < 5; k++) begin
      fc_exp = fc_exp + 2'd1;
      exp_v  = {exp_v[27:0], 2'b00, fc_exp};
      got_v  = {got_v[27:0], 2'b00, fc_log[b_fc + k]};
    end
    check_eq("wrap_fc_seq", got_v, exp_v);
    got_v = '0;
    exp_v = '0;
    for (int b = PB - 1; b >= 0; b--) exp_v = {exp_v[30:0], pat[cfg[0]][b]};
    for (int i = 0; i < PB; i++) got_v = {got_v[30:0], bits_mem[b_bits + i]};
    check_eq("wrap_first_bits", got_v, exp_v);
    check_eq("wrap_enable", ser_enable, 1);

    randomize_panels();
    one_frame(NP, "final");
    check_eq("onehot_strobes", multi_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/ip_commutator.md
# ip_commutator

Parametrised, free-running commutator that serialises several internal indicator panels into one external shift-register datastream. It is the next generation of the panel multiplexer and differs in four ways: the shift clock is derived from the system clock by a divider rather than gated; clock and latch strobes go only to the panel currently selected; panel length and count are parameters; and frame status is reported back to the host. It sits between the configuration RAM (panel order), the internal indicator panels, and the off-board panel connector.

## Interface
Parameters:
- SEL_WIDTH, 2: width of panel selector.
- PANELS, 1<<SEL_WIDTH: number of internal panels wired.
- PANEL_BITS, 144: bits shifted per panel.
- BIT_WIDTH, 8: counter width; must satisfy PANEL_BITS <= 2^BIT_WIDTH.
- DIV, 250: clk_in cycles per half shift-clock period; legal values are 2 or more.
- DIV_WIDTH, 8: divider counter width.
- FC_WIDTH, 16: frame counter width.

Ports:
- clk_in, input, 1: sole clock. All logic runs on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- run, input, 1: start and continue frames.
- ip_count, input, SEL_WIDTH+1: number of panels in the chain.
- ip_step, output, SEL_WIDTH: index into the config RAM.
- ip_sel, input, SEL_WIDTH: panel for the current step. It is combinational from ip_step and valid in the same cycle.
- ip_clk, output, [0:PANELS-1]: per-panel one-cycle shift-advance strobe.
- ip_latch, output, [0:PANELS-1]: per-panel one-cycle snapshot strobe.
- ip_data, input, [0:PANELS-1]: current bit of each panel.
- ser_clk, output, 1: external shift clock.
- ser_data, output, 1: external data.
- ser_latch, output, 1: external latch.
- ser_enable, output, 1: external output enable.
- busy, output, 1: high while a frame is in progress.
- frame_done, output, 1: one-cycle pulse at the end of each frame.
- frame_count, output, FC_WIDTH: completed frames. Wraps modulo 2^FC_WIDTH.

## Operation
- States: IDLE, LOAD, LO, HI, LATCH.
- **IDLE**
  - If run=1 and 1 <= ip_count <= PANELS, capture ip_count into n_q, set ip_step <= n_q-1, and go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD** (1 cycle)
  - ip_latch[ip_sel]=1 for this cycle; every other ip_latch bit is 0.
  - Clear the bit counter and go to LO.
- **LO** (DIV cycles)
  - ser_clk=0.
  - Every cycle, ser_data <= ip_data[ip_sel].
  - Go to HI.
- **HI** (DIV cycles)
  - ser_clk=1; ser_data is held.
  - In the final HI cycle, ip_clk[ip_sel]=1.
  - Then:
    - if the bit counter is below PANEL_BITS-1, increment it and go to LO;
    - else if ip_step != 0, set ip_step <= ip_step-1 and go to LOAD;
    - else go to LATCH.
- **LATCH** (DIV cycles)
  - ser_latch=1, ser_clk=0.
  - In the final cycle:
    - frame_done=1;
    - frame_count increments;
    - ser_enable <= 1, sticky until reset;
    - if run=1 and ip_count is legal, reload n_q and ip_step and go to LOAD;
    - otherwise go to IDLE.
- Panels are shifted from the highest step down to step 0.
- busy=0 only in IDLE.
- An illegal ip_count (0 or greater than PANELS) never starts a frame.
- ip_count changes during a frame are ignored; n_q is used.
- If run falls mid-frame, the current frame completes; the block then goes to IDLE.
- **Reset values:** state=IDLE, ip_step=0, ser_clk=0, ser_data=0, ser_latch=0, ser_enable=0, busy=0, frame_done=0, frame_count=0, all ip_clk=0, all ip_latch=0.
- Reset asserted mid-frame forces every output to its reset value immediately, with no completion of the frame.

## Timing
- ser_clk, ser_data, ser_latch, ser_enable, busy, frame_done, and ip_step are registered outputs.
- ip_clk and ip_latch are decoded from registered state and ip_sel.
- Each bit takes 2*DIV cycles.
- The rising edge of ser_clk occurs DIV cycles after LO entry, so data is stable for at least DIV-1 cycles before it.
- Frame length is N*(1+2*DIV*PANEL_BITS) + DIV cycles, where N is the captured ip_count.
- Back-to-back frames have no idle gap.
- Latency from run=1 in IDLE to the first LO cycle is 2 cycles: the IDLE capture cycle plus LOAD.
- At most one ip_clk bit and one ip_latch bit are high in any cycle.

## Test plan
- **Single panel.** PANEL_BITS=4, DIV=2, PANELS=4, ip_count=1, panel 2 pattern 1011.
  - ser_data samples at the rising edges of ser_clk are 1,0,1,1.
  - ser_latch is high for 2 cycles, then frame_done fires.
  - Frame length is 19 cycles.
  - Only ip_clk[2] and ip_latch[2] ever toggle.
- **Multi-panel order.** ip_count=3 and the config RAM maps steps 2,1,0 to panels 3,0,1.
  - Data from panels 3,0,1 appears in that order.
  - ip_step walks 2,1,0.
  - One ip_latch pulse per panel, 4 ip_clk pulses each.
  - frame_count reaches 1 and ser_enable rises at the end of the frame.
- **Illegal count.** ip_count=0, and separately ip_count=5 with PANELS=4, and run=1.
  - busy stays 0 and no strobes occur.
- **Run drop.** Deassert run mid-frame.
  - The frame completes, frame_done pulses once, and the block returns to IDLE.
  - With run held high, frames are continuous: the next LOAD immediately follows LATCH.
- **Reset mid-frame.** Assert reset_n=0 during HI of panel 1.
  - All outputs go to their reset values asynchronously, and ser_enable returns to 0.
  - A restart yields a correct full frame.
- **Counter wrap.** FC_WIDTH=2, run 5 frames.
  - frame_count reads 1,2,3,0,1.
